// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the frame-buffer port arbiter.
// The tag travels with each command so read data can be steered back to its requester.
package sram_arb_pkg;

    localparam logic [1:0] CLI_DISP = 2'd0;
    localparam logic [1:0] CLI_GAME = 2'd1;
    localparam logic [1:0] CLI_LOAD = 2'd2;

    localparam int BURST_W = 4;

    typedef struct packed {
        logic       is_read;
        logic [1:0] idx;
    } tag_t;

    localparam tag_t TAG_NONE = '{is_read: 1'b0, idx: 2'd0};

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin picker for the game-logic and image-loader clients.
// The pointer favours whichever client was not picked last.
module sram_arb_rr2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req1,
    input  logic       req2,
    input  logic       advance,
    output logic [1:0] pick
);

    logic favour2;

    always_comb begin
        pick = 2'b00;
        if (req1 && (!req2 || !favour2))
            pick = 2'b01;
        else if (req2)
            pick = 2'b10;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            favour2 <= 1'b0;
        else if (advance && (pick != 2'b00))
            favour2 <= pick[0];
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one block-RAM port between display scan-out (priority, burst-limited)
// and two round-robin clients; registers the command and returns reads 2 cycles later.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int DISP_MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [DATA_WIDTH-1:0] wdata2,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam logic [BURST_W-1:0] MAX_BURST = BURST_W'(DISP_MAX_BURST);

    logic [BURST_W-1:0]    burst_cnt;
    logic [1:0]            rr_pick;
    logic                  others_req;
    logic                  disp_win;
    logic                  accept;
    logic [1:0]            sel;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    tag_t                  tag_d1;
    tag_t                  tag_d2;

    // Handshake: a client holds req[k] (and its we/addr/wdata) until it sees gnt[k];
    // the command is taken on the rising edge where req[k] & gnt[k], and req may drop after that.
    assign others_req = req[CLI_GAME] | req[CLI_LOAD];
    assign disp_win   = req[CLI_DISP] && ((burst_cnt < MAX_BURST) || !others_req);

    sram_arb_rr2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req1    (req[CLI_GAME]),
        .req2    (req[CLI_LOAD]),
        .advance (!disp_win),
        .pick    (rr_pick)
    );

    assign gnt    = disp_win ? 3'b001 : {rr_pick, 1'b0};
    assign accept = |(req & gnt);

    always_comb begin
        sel = CLI_LOAD;
        if (gnt[CLI_DISP])
            sel = CLI_DISP;
        else if (gnt[CLI_GAME])
            sel = CLI_GAME;
        case (sel)
            CLI_DISP: begin sel_we = we[0]; sel_addr = addr0; sel_wdata = wdata0; end
            CLI_GAME: begin sel_we = we[1]; sel_addr = addr1; sel_wdata = wdata1; end
            default:  begin sel_we = we[2]; sel_addr = addr2; sel_wdata = wdata2; end
        endcase
    end

    // Counter only measures display grants that delay a waiting round-robin client.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            burst_cnt <= '0;
        else if (!others_req || gnt[CLI_GAME] || gnt[CLI_LOAD])
            burst_cnt <= '0;
        else if (gnt[CLI_DISP])
            burst_cnt <= burst_cnt + BURST_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            tag_d1     <= TAG_NONE;
            tag_d2     <= TAG_NONE;
        end else begin
            sram_en <= accept;
            sram_we <= accept && sel_we;
            if (accept) begin
                sram_addr  <= sel_addr;
                sram_wdata <= sel_wdata;
            end
            tag_d1 <= '{is_read: accept && !sel_we, idx: sel};
            tag_d2 <= tag_d1;
        end
    end

    always_comb begin
        rvalid = 3'b000;
        if (tag_d2.is_read)
            rvalid[tag_d2.idx] = 1'b1;
    end

    assign rdata = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a write-first, 1-cycle registered block-RAM model.
module tb_sram_arbiter;

    logic        clk;
    logic        reset_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [15:0] addr0, addr1, addr2;
    logic [7:0]  wdata0, wdata1, wdata2;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [7:0]  rdata;
    logic        sram_en, sram_we;
    logic [15:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;

    int n_assert = 0;
    int n_fail   = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp_item;
    logic [2:0]  starve_seq [10] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                                     3'b001, 3'b001, 3'b001, 3'b001, 3'b100};

    sram_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .we         (we),
        .addr0      (addr0),
        .addr1      (addr1),
        .addr2      (addr2),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .wdata2     (wdata2),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: unwritten words read as a fixed function of their address
    logic [7:0] mem     [0:65535];
    bit         wr_done [0:65535];

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h4A;
    endfunction

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                mem[sram_addr]     <= sram_wdata;
                wr_done[sram_addr] <= 1'b1;
                sram_rdata         <= sram_wdata;
            end else begin
                sram_rdata <= wr_done[sram_addr] ? mem[sram_addr] : init_val(sram_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] w);
        req = r;
        we  = w;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req = '0; we = '0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0;
        #3;
        check("reset_gnt",    32'(gnt), 32'h0);
        check("reset_rvalid", 32'(rvalid), 32'h0);
        check("reset_cmd",    32'({sram_en, sram_we, sram_addr, sram_wdata}), 32'h0);
        tick(); tick();
        reset_n = 1'b1;

        // single read by client 1 in the first cycle out of reset
        addr1 = 16'h0010;
        drive(3'b010, 3'b000);
        check("rd1_gnt", 32'(gnt), 32'h2);
        tick();
        drive(3'b000, 3'b000);
        check("rd1_cmd", 32'({sram_en, sram_we, sram_addr}), 32'({2'b10, 16'h0010}));
        check("rd1_no_early_rvalid", 32'(rvalid), 32'h0);
        tick();
        check("rd1_return", 32'({rvalid, rdata}), 32'({3'b010, 8'h5A}));
        tick();
        check("rd1_pulse_end", 32'(rvalid), 32'h0);

        // client 2 writes, client 0 reads the same address next cycle
        addr2 = 16'h1234; wdata2 = 8'hC3;
        drive(3'b100, 3'b100);
        check("wr2_gnt", 32'(gnt), 32'h4);
        tick();
        addr0 = 16'h1234;
        drive(3'b001, 3'b000);
        check("rd0_gnt", 32'(gnt), 32'h1);
        check("wr2_cmd", 32'({sram_en, sram_we, sram_addr, sram_wdata}), 32'({2'b11, 16'h1234, 8'hC3}));
        tick();
        drive(3'b000, 3'b000);
        check("wr2_no_rvalid", 32'({sram_en, sram_we, rvalid}), 32'({2'b10, 3'b000}));
        tick();
        check("rd0_return", 32'({rvalid, rdata}), 32'({3'b001, 8'hC3}));
        tick();

        // round-robin between clients 1 and 2, reads returning in accept order
        addr1 = 16'h0101; addr2 = 16'h0102;
        for (int i = 0; i < 9; i++) begin
            if (i < 6) begin
                drive(3'b110, 3'b000);
                check("rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'h2 : 32'h4);
                exp_q.push_back((i % 2 == 0) ? {3'b010, 8'h4A} : {3'b100, 8'h49});
            end else begin
                drive(3'b000, 3'b000);
            end
            if (i >= 2 && i < 8) begin
                exp_item = exp_q.pop_front();
                check("rr_return", 32'({rvalid, rdata}), 32'(exp_item));
            end
            if (i == 8)
                check("rr_drained", 32'(rvalid), 32'h0);
            tick();
        end

        // starvation bound with all three clients writing
        addr0 = 16'h2000; addr1 = 16'h2001; addr2 = 16'h2002;
        for (int i = 0; i < 10; i++) begin
            drive(3'b111, 3'b111);
            check("starve_gnt", 32'(gnt), 32'(starve_seq[i]));
            tick();
        end
        drive(3'b000, 3'b000);
        check("starve_no_rvalid", 32'(rvalid), 32'h0);
        tick(); tick();

        // reset asserted while a client-2 read is in flight
        addr2 = 16'h0102;
        drive(3'b100, 3'b000);
        check("rst_rd_gnt", 32'(gnt), 32'h4);
        tick();
        req = 3'b000;
        reset_n = 1'b0;
        #1;
        check("rst_en_low", 32'({sram_en, rvalid}), 32'h0);
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rst_no_rvalid", 32'({sram_en, rvalid}), 32'h0);
            tick();
        end

        // idle
        for (int i = 0; i < 10; i++) begin
            drive(3'b000, 3'b000);
            check("idle", 32'({gnt, sram_en, rvalid}), 32'h0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
